// File: rtl/peri_bridge_pkg.sv
// Shared types and helpers for the peripheral bus bridge: FSM state encoding,
// the buffered request record and the address-window legality check.
package peri_bridge_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_IDLE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP,
    ST_GAP
  } state_e;

  // One buffered core request, exactly as presented on the OBI side.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // True when the address falls inside the peripheral window.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

  // The peripheral only understands full-word accesses inside its window.
  function automatic logic is_legal(input req_t        req,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return in_window(req.addr, base, mask) && (req.be == 4'hF);
  endfunction

endpackage

// File: rtl/peri_req_fifo.sv
// Synchronous request FIFO. Pushes into a full FIFO and pops from an empty one
// are ignored, so the caller may drive raw strobes. Full/empty come from an
// occupancy counter; DEPTH must be a power of two so the pointers wrap freely.
module peri_req_fifo
  import peri_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  req_t i_push_data,
  input  logic i_pop,
  output req_t o_pop_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage written on accepted pushes.
  // NOTE: the storage array has no reset; validity is defined solely by the
  // pointers and count, and an unreset array maps onto plain RAM/regfile cells.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/peri_bus_bridge.sv
// OBI-style request/grant/rvalid bus to single-cycle peripheral command
// strobes. Requests are buffered in a small FIFO and served strictly in order;
// illegal accesses are answered with an error and never reach the peripheral,
// and each issued command is followed by CMD_GAP idle cycles.
module peri_bus_bridge
  import peri_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK  = DEF_ADDR_MASK,
  parameter logic [31:0] IDLE_ADDR  = DEF_IDLE_ADDR,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CMD_GAP    = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] peri_address_o,
  output logic [31:0] peri_data_o,
  input  logic [31:0] peri_data_i,
  output logic        busy_o
);

  // Counter preloads: the read wait and the gap both end on the cycle the
  // counter reads zero, hence the minus one.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [2:0] GAP_LOAD = (CMD_GAP > 0) ? 3'(CMD_GAP - 1) : 3'd0;
  localparam bit         HAS_GAP  = (CMD_GAP != 0);

  state_e r_state;
  state_e w_next_state;

  req_t  w_push_req;
  req_t  w_head;
  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_pop;
  logic  w_head_legal;

  logic [31:0] r_peri_addr;
  logic [31:0] r_peri_data;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_we;
  logic        r_issued;
  logic [2:0]  r_cnt;

  // Grant depends only on the registered full flag, so a pop in the same
  // cycle never opens an extra slot.
  assign gnt_o        = !rst_i && !w_full;
  assign w_push       = req_i && gnt_o;
  assign w_push_req   = '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};
  assign w_pop        = (r_state == ST_IDLE) && !w_empty;
  assign w_head_legal = is_legal(w_head, BASE_ADDR, ADDR_MASK);

  peri_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state selection.
  // NOTE: the default assignment up front keeps this block purely
  // combinational; any path that skipped it would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_next_state = w_head_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE:   w_next_state = r_we ? ST_RESP : ST_WAIT_RD;
      ST_WAIT_RD: if (r_cnt == 3'd0) w_next_state = ST_RESP;
      ST_RESP:    w_next_state = (HAS_GAP && r_issued) ? ST_GAP : ST_IDLE;
      ST_GAP:     if (r_cnt == 3'd0) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Transaction context: command registers, response data and the shared
  // latency/gap counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_peri_addr <= IDLE_ADDR;
      r_peri_data <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_issued    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_we     <= w_head.we;
            r_err    <= !w_head_legal;
            r_issued <= w_head_legal;
            r_rdata  <= '0;
            if (w_head_legal) begin
              r_peri_addr <= w_head.addr;
              r_peri_data <= w_head.we ? w_head.wdata : 32'h0;
            end
          end
        end
        ST_ISSUE: begin
          if (!r_we) r_cnt <= LAT_LOAD;
        end
        ST_WAIT_RD: begin
          if (r_cnt == 3'd0) r_rdata <= peri_data_i;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        ST_RESP: begin
          if (HAS_GAP && r_issued) r_cnt <= GAP_LOAD;
        end
        ST_GAP: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state: the command is visible only in ISSUE and the
  // response only in RESP; everywhere else the buses rest at idle values.
  always_comb begin
    rvalid_o       = 1'b0;
    err_o          = 1'b0;
    rdata_o        = '0;
    peri_address_o = IDLE_ADDR;
    peri_data_o    = '0;
    busy_o         = (r_state != ST_IDLE) || !w_empty;
    case (r_state)
      ST_ISSUE: begin
        peri_address_o = r_peri_addr;
        peri_data_o    = r_peri_data;
      end
      ST_RESP: begin
        rvalid_o = 1'b1;
        err_o    = r_err;
        rdata_o  = r_rdata;
      end
      default: begin
        rvalid_o = 1'b0;
      end
    endcase
  end

endmodule
